// File: rtl/exe_mem_stage_elastic_pkg.sv
// Shared definitions for the elastic EXE->MEM stage: widths, storage state encoding, payload layout.
package exe_mem_stage_elastic_pkg;

    localparam int WORD_LEN          = 32'd32;
    localparam int REG_FILE_ADDR_LEN = 32'd5;

    typedef enum logic [1:0] {
        EM_EMPTY = 2'd0,
        EM_ONE   = 2'd1,
        EM_FULL  = 2'd2
    } em_state_e;

    // Control bits sit at the bottom of the payload so the buffer can clear them as a block.
    localparam int EM_CTRL_W       = 32'd3;
    localparam int EM_WB_EN_BIT    = 32'd0;
    localparam int EM_MEM_R_EN_BIT = 32'd1;
    localparam int EM_MEM_W_EN_BIT = 32'd2;

    function automatic int em_payload_w(input int word_len, input int reg_len);
        return EM_CTRL_W + 32'd3 * word_len + reg_len;
    endfunction

    localparam int EM_PAYLOAD_W = em_payload_w(WORD_LEN, REG_FILE_ADDR_LEN);
    localparam int EM_DEST_LSB  = EM_CTRL_W;
    localparam int EM_PC_LSB    = EM_DEST_LSB + REG_FILE_ADDR_LEN;
    localparam int EM_ALU_LSB   = EM_PC_LSB + WORD_LEN;
    localparam int EM_ST_LSB    = EM_ALU_LSB + WORD_LEN;

endpackage

// File: rtl/exe_mem_stage_elastic_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer with flush. The low CLR_W payload bits
// are zeroed whenever an entry is vacated, so a bubble never carries stale control.
module pipe_skid_buf
    import exe_mem_stage_elastic_pkg::*;
#(
    parameter int W     = 32'd8,
    parameter int CLR_W = 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam logic [W-1:0] KEEP_MASK = {W{1'b1}} << CLR_W;

    em_state_e      state_r;
    logic [W-1:0]   main_r;
    logic [W-1:0]   skid_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           accept_s;
    logic           pop_s;

    assign accept_s  = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

    // Occupancy FSM with registered handshake flags; flush keeps data but drops control and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EM_EMPTY;
            main_r      <= {W{1'b0}};
            skid_r      <= {W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= EM_EMPTY;
            main_r      <= main_r & KEEP_MASK;
            skid_r      <= skid_r & KEEP_MASK;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EM_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= in_data;
                        state_r     <= EM_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                EM_ONE: begin
                    if (accept_s && pop_s) begin
                        main_r <= in_data;
                    end else if (accept_s) begin
                        skid_r     <= in_data;
                        state_r    <= EM_FULL;
                        in_ready_r <= 1'b0;
                    end else if (pop_s) begin
                        main_r      <= main_r & KEEP_MASK;
                        state_r     <= EM_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                EM_FULL: begin
                    if (pop_s) begin
                        main_r     <= skid_r;
                        skid_r     <= skid_r & KEEP_MASK;
                        state_r    <= EM_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    main_r      <= main_r & KEEP_MASK;
                    skid_r      <= skid_r & KEEP_MASK;
                    state_r     <= EM_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_stage_elastic.sv
// Elastic EXE->MEM pipeline register: packs the EXE result into one payload carried by a 2-entry
// skid buffer. Optional perf counters are enabled with `EXE_MEM_PERF_CNT_EN.
module exe_mem_stage_elastic
    import exe_mem_stage_elastic_pkg::*;
#(
    parameter int WORD_LEN     = exe_mem_stage_elastic_pkg::WORD_LEN,
    parameter int REG_ADDR_LEN = exe_mem_stage_elastic_pkg::REG_FILE_ADDR_LEN,
    parameter int CNT_W        = 32'd16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic [WORD_LEN-1:0]     alu_res_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic [WORD_LEN-1:0]     pc,
    output logic [WORD_LEN-1:0]     alu_res,
    output logic [WORD_LEN-1:0]     st_val,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int PW       = em_payload_w(WORD_LEN, REG_ADDR_LEN);
    localparam int DEST_LSB = EM_CTRL_W;
    localparam int PC_LSB   = DEST_LSB + REG_ADDR_LEN;
    localparam int ALU_LSB  = PC_LSB + WORD_LEN;
    localparam int ST_LSB   = ALU_LSB + WORD_LEN;

    logic [PW-1:0] in_payload_s;
    logic [PW-1:0] out_payload_s;
    logic          out_valid_s;

    assign in_payload_s = {st_val_in, alu_res_in, pc_in, dest_in, mem_w_en_in, mem_r_en_in, wb_en_in};

    pipe_skid_buf #(
        .W     (PW),
        .CLR_W (EM_CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_payload_s)
    );

    // Outputs come straight from the buffer's main register; vacated entries already hold zero control.
    assign out_valid = out_valid_s;
    assign wb_en     = out_payload_s[EM_WB_EN_BIT];
    assign mem_r_en  = out_payload_s[EM_MEM_R_EN_BIT];
    assign mem_w_en  = out_payload_s[EM_MEM_W_EN_BIT];
    assign dest      = out_payload_s[DEST_LSB +: REG_ADDR_LEN];
    assign pc        = out_payload_s[PC_LSB +: WORD_LEN];
    assign alu_res   = out_payload_s[ALU_LSB +: WORD_LEN];
    assign st_val    = out_payload_s[ST_LSB +: WORD_LEN];

`ifdef EXE_MEM_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    // Saturating perf counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (!out_valid_s && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`else
    assign stall_cnt  = {CNT_W{1'b0}};
    assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exe_mem_stage_elastic.sv
// Directed, table-driven bench for exe_mem_stage_elastic plus hand-written counter and ordering sequences.
module tb_exe_mem_stage_elastic;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] pc_in, alu_res_in, st_val_in;
    logic [4:0]  dest_in;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] pc, alu_res, st_val;
    logic [4:0]  dest;
    logic [3:0]  stall_cnt, bubble_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    exe_mem_stage_elastic #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .pc_in(pc_in), .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .pc(pc), .alu_res(alu_res), .st_val(st_val), .dest(dest),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [31:0] pc;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                                input logic [31:0] p, input logic ov, input logic ir, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.pc = p;
        v.e_ov = ov; v.e_ir = ir; v.e_pc = ep;
        return v;
    endfunction

    // Every other payload field is a fixed function of pc, so one expected pc implies all fields.
    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy, input logic [31:0] p);
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        pc_in = p; alu_res_in = p << 1; st_val_in = p << 2; dest_in = p[6:2];
        wb_en_in = 1'b1; mem_r_en_in = p[2]; mem_w_en_in = ~p[2];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic ir, input logic [31:0] ep);
        logic [4:0] ed;
        ed = ep[6:2];
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, ir});
        chk({tag, " pc"},        pc,      ep);
        chk({tag, " alu_res"},   alu_res, ep << 1);
        chk({tag, " st_val"},    st_val,  ep << 2);
        chk({tag, " dest"},      {27'd0, dest}, {27'd0, ed});
        chk({tag, " wb_en"},     {31'd0, wb_en},    {31'd0, ov});
        chk({tag, " mem_r_en"},  {31'd0, mem_r_en}, {31'd0, ov & ep[2]});
        chk({tag, " mem_w_en"},  {31'd0, mem_w_en}, {31'd0, ov & ~ep[2]});
    endtask

    logic [31:0] q[$];
    logic [31:0] iv_pat   = 32'hB6DB_F3A7;
    logic [31:0] ordy_pat = 32'h5AC3_9E6D;

    initial begin
        //               rst   flush iv    ordy  pc_in      ov    ir    pc
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 1'b1, 32'h00);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h14);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h18);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h18);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 32'h20);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 1'b1, 1'b0, 32'h20);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 1'b1, 1'b0, 32'h20);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 1'b1, 32'h24);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 1'b1, 1'b0, 32'h24);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 32'h28);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h28);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h40);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 32'h40);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 1'b1, 32'h40);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h40);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h50, 1'b1, 1'b1, 32'h50);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h50);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 1'b1, 1'b1, 32'h60);
        vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h64, 1'b0, 1'b1, 32'h00);
        vecs[21] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h70, 1'b0, 1'b1, 32'h00);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h00);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].pc);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_pc);
            chk($sformatf("vec%0d stall_cnt_reset", i), {28'd0, stall_cnt}, 32'd0 + ((i < 2) ? 32'd0 : {28'd0, stall_cnt}));
        end

        // Counters: reset, one push then 20 stalled cycles, then reset mid-stall.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00);
        tick();
        chk("cnt reset stall", {28'd0, stall_cnt}, 32'd0);
        chk("cnt reset bubble", {28'd0, bubble_cnt}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h00);
        for (int c = 0; c < 20; c++) tick();
        chk_outs("stall hold", 1'b1, 1'b1, 32'h80);
`ifdef EXE_MEM_PERF_CNT_EN
        chk("stall_cnt saturated", {28'd0, stall_cnt}, 32'd15);
        chk("bubble_cnt one", {28'd0, bubble_cnt}, 32'd1);
`else
        chk("stall_cnt tied", {28'd0, stall_cnt}, 32'd0);
        chk("bubble_cnt tied", {28'd0, bubble_cnt}, 32'd0);
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00);
        tick();
        chk("rst mid-stall stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst mid-stall bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
        chk_outs("rst mid-stall", 1'b0, 1'b1, 32'h00);

        // Ordering under irregular valid/ready patterns against a queue model.
        begin
            logic [31:0] nxt_pc;
            int pushed, popped;
            logic iv, ordy, acc, pop;
            nxt_pc = 32'h100; pushed = 0; popped = 0;
            for (int c = 0; c < 40; c++) begin
                iv   = (c < 32) ? iv_pat[c] : 1'b0;
                ordy = (c < 32) ? ordy_pat[c] : 1'b1;
                drive(1'b0, 1'b0, iv, ordy, nxt_pc);
                chk($sformatf("ord%0d out_valid", c), {31'd0, out_valid}, {31'd0, (q.size() > 0)});
                chk($sformatf("ord%0d in_ready", c), {31'd0, in_ready}, {31'd0, (q.size() < 2)});
                acc = iv && (q.size() < 2);
                pop = ordy && (q.size() > 0);
                if (pop) begin
                    chk($sformatf("ord%0d pc", c), pc, q[0]);
                    chk($sformatf("ord%0d alu_res", c), alu_res, q[0] << 1);
                    void'(q.pop_front());
                    popped++;
                end
                if (acc) begin
                    q.push_back(nxt_pc);
                    pushed++;
                    nxt_pc = nxt_pc + 32'd4;
                end
                tick();
            end
            chk("ord drained", q.size(), 32'd0);
            chk("ord count", popped, pushed);
            chk("ord final out_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
